// File: rtl/alu_arb2_pkg.sv
// Shared constants for alu_arb2: opcodes, FSM state encoding, filler bytes,
// and the registered request control payload.
package alu_arb2_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_ADD  = 3'b010;
  localparam op_t OP_FA5A = 3'b011;
  localparam op_t OP_FA5B = 3'b100;
  localparam op_t OP_F5A  = 3'b101;
  localparam op_t OP_SUB  = 3'b110;
  localparam op_t OP_SLTU = 3'b111;

  localparam logic [7:0] FILL_A5 = 8'hA5;
  localparam logic [7:0] FILL_5A = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Control fields captured alongside the operands on accept
  typedef struct packed {
    op_t  op;
    logic id;
  } ctl_t;

endpackage

// File: rtl/alu_arb2_alu_core.sv
// Combinational ALU for alu_arb2. Signed-overflow logic is only built when
// ALU_ARB2_OVF_EN is defined; otherwise ovf is tied low.
module alu_core
  import alu_arb2_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  output logic [W-1:0] res,
  output logic         co,
  output logic         ovf
);

  localparam int unsigned SW = W + 1;

  logic         is_sub;
  logic         is_arith;
  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  // Shared adder: SUB is A + ~B + 1
  always_comb begin
    is_sub   = (op == OP_SUB);
    is_arith = (op == OP_ADD) || (op == OP_SUB);
    b_eff    = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + SW'(is_sub);
  end

  // Result select and flags
  always_comb begin
    res = '0;
    unique case (op)
      OP_AND:           res = a & b;
      OP_OR:            res = a | b;
      OP_ADD, OP_SUB:   res = sum[W-1:0];
      OP_SLTU:          res = W'(a < b);
      OP_FA5A, OP_FA5B: res = {(W/8){FILL_A5}};
      OP_F5A:           res = {(W/8){FILL_5A}};
      default:          res = '0;
    endcase
    co = is_arith ? sum[W] : 1'b0;
`ifdef ALU_ARB2_OVF_EN
    ovf = is_arith && (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
`else
    ovf = 1'b0;
`endif
  end

endmodule

// File: rtl/alu_arb2.sv
// Two-requester round-robin front end for a shared ALU.
// Optional feature macro: ALU_ARB2_OVF_EN (signed-overflow flag on rsp_ovf).
module alu_arb2
  import alu_arb2_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic [2:0]   r0_op,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  input  logic [2:0]   r1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_res,
  output logic         rsp_co,
  output logic         rsp_zero,
  output logic         rsp_ovf
);

  state_t       state;
  state_t       state_nxt;
  logic         last_grant;
  logic         grant_id;
  logic         accept;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  ctl_t         ctl_q;
  logic [W-1:0] alu_res;
  logic         alu_co;
  logic         alu_ovf;

  // Arbiter: single valid wins; on a tie the requester not granted last wins
  always_comb begin
    grant_id = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_id = ~last_grant;
    end else if (r1_valid) begin
      grant_id = 1'b1;
    end
    accept = (state == ST_IDLE) && !rst && (r0_valid || r1_valid);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs; ready stays low throughout reset
  always_comb begin
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    rsp_valid = (state == ST_RESP);
    if (accept) begin
      r0_ready = ~grant_id;
      r1_ready = grant_id;
    end
  end

  // Capture the granted request and advance the round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      ctl_q      <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      a_q        <= grant_id ? r1_a : r0_a;
      b_q        <= grant_id ? r1_b : r0_b;
      ctl_q.op   <= grant_id ? r1_op : r0_op;
      ctl_q.id   <= grant_id;
      last_grant <= grant_id;
    end
  end

  alu_core #(.W(W)) u_core (
    .a   (a_q),
    .b   (b_q),
    .op  (ctl_q.op),
    .res (alu_res),
    .co  (alu_co),
    .ovf (alu_ovf)
  );

  // Register the ALU result in EXEC; held unchanged through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_res  <= '0;
      rsp_co   <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_res  <= alu_res;
      rsp_co   <= alu_co;
      rsp_zero <= (alu_res == '0);
      rsp_ovf  <= alu_ovf;
      rsp_id   <= ctl_q.id;
    end
  end

endmodule

// File: tb/tb_alu_arb2.sv
// Self-checking bench for alu_arb2: directed scenarios followed by random
// transactions checked against an arithmetic reference model.
module tb_alu_arb2;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r1_valid;
  logic         r0_ready, r1_ready;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]   r0_op, r1_op;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_res;
  logic         rsp_co, rsp_zero, rsp_ovf;

  int   checks = 0;
  int   errors = 0;
  logic last_g = 1'b1;

  alu_arb2 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_op     (r0_op),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_op     (r1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_co    (rsp_co),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model from the opcode definitions using wide arithmetic
  function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic co, output logic ovf);
    longint sa, sb, sr;
    logic [32:0] s;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'h0;
    co  = 1'b0;
    ovf = 1'b0;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        s   = {1'b0, a} + {1'b0, b};
        res = s[31:0];
        co  = s[32];
        sr  = sa + sb;
        ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b110: begin
        res = a - b;
        co  = (a >= b);
        sr  = sa - sb;
        ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b111:         res = (a < b) ? 32'd1 : 32'd0;
      3'b101:         res = 32'h5A5A5A5A;
      default:        res = 32'hA5A5A5A5;
    endcase
`ifndef ALU_ARB2_OVF_EN
    ovf = 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // One request/response round trip; called at posedge+1 with the DUT idle
  task automatic run_txn(input string tag, input logic v0, input logic v1,
                         input int hold, input logic scramble);
    logic        eg, eco, eovf;
    logic [31:0] ea, eb, er;
    logic [2:0]  eo;
    r0_valid = v0;
    r1_valid = v1;
    #1;
    eg = (v0 && v1) ? ~last_g : v1;
    chk({tag, "_r0_ready"}, 32'(r0_ready), 32'(!eg));
    chk({tag, "_r1_ready"}, 32'(r1_ready), 32'(eg));
    ea = eg ? r1_a : r0_a;
    eb = eg ? r1_b : r0_b;
    eo = eg ? r1_op : r0_op;
    last_g = eg;
    model(eo, ea, eb, er, eco, eovf);
    @(posedge clk); #1;
    chk({tag, "_exec_ready"}, 32'({r0_ready, r1_ready}), 32'd0);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    if (scramble) begin
      if (eg) begin r1_a = $urandom; r1_b = $urandom; r1_op = 3'($urandom); end
      else    begin r0_a = $urandom; r0_b = $urandom; r0_op = 3'($urandom); end
    end
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(rsp_id),    32'(eg));
    chk({tag, "_res"},   rsp_res,        er);
    chk({tag, "_co"},    32'(rsp_co),    32'(eco));
    chk({tag, "_zero"},  32'(rsp_zero),  32'(er == 32'h0));
    chk({tag, "_ovf"},   32'(rsp_ovf),   32'(eovf));
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_res"},   rsp_res,        er);
      chk({tag, "_hold_flags"}, 32'({rsp_id, rsp_co, rsp_zero, rsp_ovf}),
          32'({eg, eco, er == 32'h0, eovf}));
      chk({tag, "_hold_ready"}, 32'({r0_ready, r1_ready}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0] sel;
    rst = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b0;
    r0_a = '0; r0_b = '0; r0_op = '0; r1_a = '0; r1_b = '0; r1_op = '0;
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", 32'({r0_ready, r1_ready}), 32'd0);
    chk("rst_rsp",   32'({rsp_valid, rsp_id, rsp_co, rsp_zero, rsp_ovf}), 32'd0);
    chk("rst_res",   rsp_res, 32'd0);
    @(posedge clk); #1;
    chk("rst_ready_hold", 32'({r0_ready, r1_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;

    // r0 ADD wraps to zero with carry
    r0_a = 32'hFFFFFFFF; r0_b = 32'd1; r0_op = 3'b010;
    run_txn("add_wrap", 1'b1, 1'b0, 0, 1'b1);
    chk("add_wrap_res_const", rsp_res, 32'd0);

    // SLTU and filler opcodes
    r0_a = 32'd3; r0_b = 32'd5; r0_op = 3'b111;
    run_txn("sltu", 1'b1, 1'b0, 0, 1'b0);
    r0_op = 3'b101;
    run_txn("fill5a", 1'b1, 1'b0, 0, 1'b0);
    r0_op = 3'b011;
    run_txn("filla5", 1'b1, 1'b0, 0, 1'b0);

    // r1 SUB crossing the signed boundary
    r0_valid = 1'b0;
    r1_a = 32'h80000000; r1_b = 32'd1; r1_op = 3'b110;
    run_txn("sub_ovf", 1'b0, 1'b1, 0, 1'b0);
    r1_valid = 1'b0;

    // Both held: grants alternate 0,1,0
    r0_a = 32'h12345678; r0_b = 32'h0F0F0F0F; r0_op = 3'b000;
    r1_a = 32'h00000010; r1_b = 32'h00000020; r1_op = 3'b010;
    run_txn("tie0", 1'b1, 1'b1, 0, 1'b0);
    run_txn("tie1", 1'b1, 1'b1, 0, 1'b0);
    run_txn("tie2", 1'b1, 1'b1, 0, 1'b0);
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Backpressure for 5 cycles, then pending r0 accepted immediately
    r0_a = 32'hDEAD0000; r0_b = 32'h0000BEEF; r0_op = 3'b001;
    run_txn("bp", 1'b1, 1'b0, 5, 1'b0);
    r0_a = 32'h00001234; r0_b = 32'h0; r0_op = 3'b001;
    run_txn("bp_next", 1'b1, 1'b0, 0, 1'b0);

    // Reset during EXEC discards the operation
    r0_valid = 1'b1; r1_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_exec_rsp",   32'({rsp_valid, rsp_id, rsp_co, rsp_zero, rsp_ovf}), 32'd0);
    chk("rst_exec_res",   rsp_res, 32'd0);
    chk("rst_exec_ready", 32'({r0_ready, r1_ready}), 32'd0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_g = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
    end
    r0_op = 3'b010; r1_op = 3'b110;
    run_txn("rst_tie", 1'b1, 1'b1, 0, 1'b1);
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      r0_valid = 1'b0; r1_valid = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk); #1;
        chk("rnd_idle", 32'({r0_ready, r1_ready, rsp_valid}), 32'd0);
      end
      r0_a = rand_val(); r0_b = rand_val(); r0_op = 3'($urandom_range(0, 7));
      r1_a = rand_val(); r1_b = rand_val(); r1_op = 3'($urandom_range(0, 7));
      sel = 2'($urandom_range(1, 3));
      run_txn("rnd", sel[0], sel[1], int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
